// File: rtl/cla_sweep_checker.sv
// cla_sweep_checker
// Exhaustive self-test engine for a WIDTH-bit adder. It walks every
// {a,b,cin} combination, holds each one for SETTLE_CYCLES+1 clocks, checks the
// adder result against a behavioural sum and keeps a mismatch count and the
// first failing vector.
module cla_sweep_checker #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 cin,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH+1:0]   vec_count,
    output logic [WIDTH-1:0]     first_a,
    output logic [WIDTH-1:0]     first_b,
    output logic                 first_cin,
    output logic                 first_vld
);

    // Vector register is {a,b,cin}; counters are one bit wider so the full
    // sweep count 2^(2*WIDTH+1) is representable.
    localparam int VW = 2 * WIDTH + 1;
    localparam int CW = 2 * WIDTH + 2;
    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SW-1:0]    settle_cnt;
    logic [VW-1:0]    vec;
    logic [WIDTH:0]   expected;
    logic             mismatch;
    logic             last_vec;
    logic [CW-1:0]    err_next;
    state_t           vector_state;

    assign a   = vec[VW-1:WIDTH+1];
    assign b   = vec[WIDTH:1];
    assign cin = vec[0];

    // Reference result, mismatch flag and the saturating next error count.
    always_comb begin
        expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        mismatch = ({cout, sum} != expected);
        last_vec = &vec;
        err_next = err_count;
        if (mismatch && !(&err_count)) begin
            err_next = err_count + CW'(1);
        end
        vector_state = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort always wins, start only counts when not busy.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next = vector_state;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (settle_cnt <= SETTLE_ONE) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_vec) begin
                    state_next = DONE;
                end else begin
                    state_next = vector_state;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: vector generation, settle timing, result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_count  <= '0;
            first_a    <= '0;
            first_b    <= '0;
            first_cin  <= 1'b0;
            first_vld  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (abort) begin
                        done <= 1'b0;
                    end else if (start) begin
                        vec        <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        vec_count  <= '0;
                        first_a    <= '0;
                        first_b    <= '0;
                        first_cin  <= 1'b0;
                        first_vld  <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        vec  <= '0;
                        busy <= 1'b0;
                        done <= 1'b0;
                    end else if (settle_cnt > SETTLE_ONE) begin
                        settle_cnt <= settle_cnt - SETTLE_ONE;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        vec  <= '0;
                        busy <= 1'b0;
                        done <= 1'b0;
                    end else begin
                        vec_count <= vec_count + CW'(1);
                        err_count <= err_next;
                        if (mismatch && !first_vld) begin
                            first_a   <= a;
                            first_b   <= b;
                            first_cin <= cin;
                            first_vld <= 1'b1;
                        end
                        if (last_vec) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (err_next == '0);
                        end else begin
                            vec        <= vec + VW'(1);
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sweep_checker.sv
// tb_cla_sweep_checker
// Drives two checker instances (one vector hold of two cycles, one of a
// single cycle) against behavioural adders with selectable faults. Expected
// sweep outcomes are queued when a sweep is launched and compared when done
// rises.
module tb_cla_sweep_checker;

    localparam int WIDTH = 4;
    localparam int CW    = 2 * WIDTH + 2;
    localparam int NVEC  = 1 << (2 * WIDTH + 1);

    typedef struct {
        int errs;
        int fvld;
        int fa;
        int fb;
        int fc;
        int lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] a, b, sum;
    logic             cin, cout;
    logic             busy, done, pass, first_cin, first_vld;
    logic [CW-1:0]    err_count, vec_count;
    logic [WIDTH-1:0] first_a, first_b;

    logic             z_start = 1'b0;
    logic             z_abort = 1'b0;
    logic [WIDTH-1:0] z_a, z_b, z_sum;
    logic             z_cin, z_cout;
    logic             z_busy, z_done, z_pass, z_first_cin, z_first_vld;
    logic [CW-1:0]    z_err_count, z_vec_count;
    logic [WIDTH-1:0] z_first_a, z_first_b;

    int   fault_mode = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    // Behavioural adder with optional stuck-at faults for the main instance.
    always_comb begin
        logic [WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum  = full[WIDTH-1:0];
        cout = full[WIDTH];
        if (fault_mode == 1) cout = 1'b0;
        if (fault_mode == 2) sum[0] = 1'b0;
    end

    // Fault-free adder for the zero-settle instance.
    always_comb begin
        logic [WIDTH:0] zfull;
        zfull  = {1'b0, z_a} + {1'b0, z_b} + {{WIDTH{1'b0}}, z_cin};
        z_sum  = zfull[WIDTH-1:0];
        z_cout = zfull[WIDTH];
    end

    cla_sweep_checker #(.WIDTH(WIDTH), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_count(vec_count),
        .first_a(first_a), .first_b(first_b), .first_cin(first_cin),
        .first_vld(first_vld)
    );

    cla_sweep_checker #(.WIDTH(WIDTH), .SETTLE_CYCLES(0)) dut_zero (
        .clk(clk), .rst_n(rst_n), .start(z_start), .abort(z_abort),
        .a(z_a), .b(z_b), .cin(z_cin), .sum(z_sum), .cout(z_cout),
        .busy(z_busy), .done(z_done), .pass(z_pass),
        .err_count(z_err_count), .vec_count(z_vec_count),
        .first_a(z_first_a), .first_b(z_first_b), .first_cin(z_first_cin),
        .first_vld(z_first_vld)
    );

    // Single comparison point for every check in the bench.
    task automatic check_output(input string tag, input logic [31:0] got,
                                input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    // Independent reference for a whole sweep under the given fault.
    function automatic exp_t model_sweep(input int fault, input int settle);
        exp_t e;
        int good, seen;
        e.errs = 0; e.fvld = 0; e.fa = 0; e.fb = 0; e.fc = 0;
        for (int ia = 0; ia < (1 << WIDTH); ia++)
            for (int ib = 0; ib < (1 << WIDTH); ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    good = ia + ib + ic;
                    seen = good;
                    if (fault == 1) seen = good & ((1 << WIDTH) - 1);
                    if (fault == 2) seen = good & ~1;
                    if (seen != good) begin
                        e.errs++;
                        if (e.fvld == 0) begin
                            e.fvld = 1; e.fa = ia; e.fb = ib; e.fc = ic;
                        end
                    end
                end
        e.lat = NVEC * (settle + 1);
        return e;
    endfunction

    // Launch a sweep, wait for done with a cycle budget, then score it.
    task automatic apply_stimulus(input int sel, input int fault, input bit pulses);
        exp_t e, r;
        int   lat, budget;
        @(negedge clk);
        fault_mode = (sel == 0) ? fault : fault_mode;
        e = model_sweep((sel == 0) ? fault : 0, (sel == 0) ? 1 : 0);
        sb_q.push_back(e);
        budget = 2 * e.lat + 20;
        if (sel == 0) start = 1'b1; else z_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; z_start = 1'b0;
        lat = 0;
        while (((sel == 0) ? done : z_done) !== 1'b1 && lat < budget) begin
            start = (pulses && (lat % 37 == 5)) ? 1'b1 : 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        r = sb_q.pop_front();
        check_output("sweep_latency", lat, r.lat);
        if (sel == 0) begin
            check_output("done", done, 1);
            check_output("busy_at_done", busy, 0);
            check_output("pass", pass, (r.errs == 0) ? 1 : 0);
            check_output("err_count", err_count, r.errs);
            check_output("vec_count", vec_count, NVEC);
            check_output("first_vld", first_vld, r.fvld);
            check_output("first_a", first_a, r.fa);
            check_output("first_b", first_b, r.fb);
            check_output("first_cin", first_cin, r.fc);
            check_output("last_vector", {a, b, cin}, NVEC - 1);
        end else begin
            check_output("z_done", z_done, 1);
            check_output("z_pass", z_pass, (r.errs == 0) ? 1 : 0);
            check_output("z_err_count", z_err_count, r.errs);
            check_output("z_vec_count", z_vec_count, NVEC);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_vec"}, {a, b, cin}, 0);
        check_output({tag, "_flags"}, {busy, done, pass, first_vld}, 0);
        check_output({tag, "_counts"}, {err_count, vec_count}, 0);
        check_output({tag, "_first"}, {first_a, first_b, first_cin}, 0);
    endtask

    initial begin
        int guard;
        #3 rst_n = 1'b0;
        #10;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Correct adder, then the two stuck-at faults.
        apply_stimulus(0, 0, 1'b0);
        apply_stimulus(0, 1, 1'b0);
        apply_stimulus(0, 2, 1'b0);

        // Abort together with start while in DONE: back to IDLE, no restart.
        @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check_output("abort_done_flags", {busy, done}, 0);

        // Zero-settle instance sweeps one vector per clock.
        apply_stimulus(1, 0, 1'b0);

        // Abort while vector 99 is being held.
        @(negedge clk);
        fault_mode = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while ({a, b, cin} != 9'd99 && guard < 400) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check_output("abort_reach_vec99", guard < 400, 1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_flags", {busy, done}, 0);
        check_output("abort_vec", {a, b, cin}, 0);
        check_output("abort_vec_count", vec_count, 99);
        check_output("abort_err_count", err_count, 0);
        apply_stimulus(0, 0, 1'b0);

        // Asynchronous reset mid-sweep clears everything immediately.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Start pulses while busy must not disturb timing or results.
        apply_stimulus(0, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
